dig6_disp_arb: RTL and testbench

- Arbiter and scan scheduler that shares the board's 6-digit 7-segment display between two requesters.
- Grants ownership round-robin, with a minimum hold time and switching only at frame boundaries, so no frame ever tears.
- Latches the owner's 24-bit BCD/hex value and dot mask once per frame.
- Drives the digit-select lines and the per-digit nibble/dot into the existing segment decoder (DIG_DEC).

---
 rtl/dig6_disp_arb.sv | 156 +++++++++++++++
 tb/tb_dig6_disp_arb.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dig6_disp_arb.sv
// Two-requester arbiter and scan scheduler for a 6-digit 7-segment display.
// Optional leading-zero blanking: define DIG6_LZB_EN.
module dig6_disp_arb #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [23:0] val0,
    input  logic [23:0] val1,
    input  logic [5:0]  dot0,
    input  logic [5:0]  dot1,
    output logic [1:0]  gnt,
    output logic [0:5]  sel,
    output logic [3:0]  dig,
    output logic        dot,
    output logic        frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_FRAMES);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    logic [PW-1:0] ps_q, ps_d;
    logic [2:0]    c_q, c_d;
    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [23:0]   frame_q, frame_d;
    logic [5:0]    fdot_q, fdot_d;
    logic [5:0]    blank;
    logic          tick;
    logic          load;
    logic          lsel;

    assign tick       = (ps_q == PS_MAX);
    assign frame_done = tick && (c_q == 3'd5);
    assign gnt        = state_q;

    always_comb begin
        ps_d    = tick ? '0 : ps_q + PW'(1);
        c_d     = c_q;
        if (tick) c_d = (c_q == 3'd5) ? 3'd0 : c_q + 3'd1;
        state_d = state_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        load    = 1'b0;
        lsel    = 1'b0;
        if (frame_done) begin
            unique case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        lsel = (req == 2'b11) ? rr_q : req[1];
                        load = 1'b1;
                        state_d = lsel ? OWN1 : OWN0;
                        hold_d = '0;
                        rr_d = ~lsel;
                    end
                end
                OWN0, OWN1: begin
                    lsel = (state_q == OWN1);
                    if (hold_q + HW'(1) < HOLD_LIM) begin
                        load = 1'b1;
                        hold_d = hold_q + HW'(1);
                    end else if (req[~lsel]) begin
                        lsel = ~lsel;
                        load = 1'b1;
                        state_d = lsel ? OWN1 : OWN0;
                        hold_d = '0;
                        rr_d = ~lsel;
                    end else if (req[lsel]) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        frame_d = frame_q;
        fdot_d  = fdot_q;
        if (load) begin
            frame_d = lsel ? val1 : val0;
            fdot_d  = lsel ? dot1 : dot0;
        end
    end

`ifdef DIG6_LZB_EN
    logic [5:0] blank_q, blank_d;
    logic [5:0] lzb;
    logic       run;

    // A digit blanks only while every digit to its left is a bare zero.
    always_comb begin
        lzb = '0;
        run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run = run && (frame_d[23-4*k -: 4] == 4'h0) && !fdot_d[k];
            lzb[k] = run;
        end
        blank_d = load ? lzb : blank_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blank_q <= '0;
        else        blank_q <= blank_d;
    end

    assign blank = blank_q;
`else
    assign blank = 6'b0;
`endif

    always_comb begin
        sel = 6'b111111;
        dig = 4'h0;
        dot = 1'b0;
        if (state_q != IDLE) begin
            for (int k = 0; k < 6; k++) begin
                if (c_q == 3'(k)) begin
                    sel[k] = blank[k];
                    dig    = frame_q[23-4*k -: 4];
                    dot    = fdot_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q    <= '0;
            c_q     <= '0;
            state_q <= IDLE;
            rr_q    <= 1'b0;
            hold_q  <= '0;
            frame_q <= '0;
            fdot_q  <= '0;
        end else begin
            ps_q    <= ps_d;
            c_q     <= c_d;
            state_q <= state_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            frame_q <= frame_d;
            fdot_q  <= fdot_d;
        end
    end
endmodule

// File: tb/tb_dig6_disp_arb.sv
// Bench for dig6_disp_arb: cycle model of the display arbiter,
// directed scenarios plus randomized requests and values.
module tb_dig6_disp_arb;
    localparam int SD = 4;
    localparam int HF = 2;
    localparam int FR = 6 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [23:0] val0 = '0, val1 = '0;
    logic [5:0]  dot0 = '0, dot1 = '0;
    logic [1:0]  gnt;
    logic [0:5]  sel;
    logic [3:0]  dig;
    logic        dot;
    logic        frame_done;

    dig6_disp_arb #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .val0(val0), .val1(val1), .dot0(dot0), .dot1(dot1),
        .gnt(gnt), .sel(sel), .dig(dig), .dot(dot),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: cycles since reset, current owner, frames held.
    int          n;
    int          owner;
    int          held;
    bit          rr;
    logic [23:0] mframe;
    logic [5:0]  mdot;
    logic [5:0]  mblank;
    logic [13:0] exp_v;
    wire  [13:0] obs_v = {gnt, sel, dig, dot, frame_done};

    function automatic logic [3:0] nib(input logic [23:0] v, input int k);
        return v[23-4*k -: 4];
    endfunction

    task automatic model_load(input int j);
        bit zero_run;
        mframe = j ? val1 : val0;
        mdot   = j ? dot1 : dot0;
        mblank = '0;
`ifdef DIG6_LZB_EN
        zero_run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (nib(mframe, k) != 0 || mdot[k]) zero_run = 1'b0;
            mblank[k] = zero_run;
        end
`else
        zero_run = 1'b0;
`endif
    endtask

    task automatic model_take(input int j);
        owner = j;
        held  = 0;
        rr    = (j == 0);
        model_load(j);
    endtask

    task automatic model_frame();
        int other;
        if (owner < 0) begin
            if (req == 2'b11)  model_take(int'(rr));
            else if (req[0])   model_take(0);
            else if (req[1])   model_take(1);
        end else begin
            other = 1 - owner;
            if (held + 1 < HF) begin
                held++;
                model_load(owner);
            end else if (req[other]) model_take(other);
            else if (req[owner])     model_load(owner);
            else                     owner = -1;
        end
    endtask

    task automatic model_out();
        int c;
        logic [0:5] es;
        logic [1:0] eg;
        logic [3:0] ed;
        logic       edt;
        c   = (n / SD) % 6;
        es  = 6'b111111;
        eg  = 2'b00;
        ed  = 4'h0;
        edt = 1'b0;
        if (owner >= 0) begin
            eg = (owner == 0) ? 2'b01 : 2'b10;
            es[c] = mblank[c];
            ed  = nib(mframe, c);
            edt = mdot[c];
        end
        exp_v = {eg, es, ed, edt, 1'((n % FR) == FR - 1)};
    endtask

    task automatic model_reset();
        n = 0; owner = -1; held = 0; rr = 0;
        mframe = '0; mdot = '0; mblank = '0;
    endtask

    task automatic step();
        if ((n % FR) == FR - 1) model_frame();
        @(posedge clk);
        n++;
        #1;
        model_out();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        model_out();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 2'b11; val0 = 24'h987654; dot0 = 6'h3f;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        model_out();
        if (obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL reset got %b exp %b", obs_v, exp_v);
        end
        vectors++;
        req = 2'b00;
        #2;
        rst_n = 1'b1;
        repeat (30) begin
            step();
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL idle n=%0d got %b exp %b", n, obs_v, exp_v);
            end
            vectors++;
        end
    endtask

    task automatic test_single_owner();
        req = 2'b01; val0 = 24'h123456; dot0 = 6'b000100;
        do_reset();
        repeat (60) begin
            step();
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL single n=%0d got %b exp %b", n, obs_v, exp_v);
            end
            vectors++;
            if (n == 24 || n == 28 || n == 44) begin
                if ({gnt, sel, dig} !== {2'b01, 6'b111111 ^ (6'b100000 >> ((n - 24) / 4)), 4'(1 + (n - 24) / 4)}) begin
                    miscompares++;
                    $display("FAIL single_dir n=%0d got %b %b %h", n, gnt, sel, dig);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_round_robin();
        req = 2'b11; val0 = 24'hAAAAAA; val1 = 24'hBBBBBB;
        do_reset();
        repeat (130) begin
            step();
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL rr n=%0d got %b exp %b", n, obs_v, exp_v);
            end
            vectors++;
            if (n == 24 || n == 72 || n == 120) begin
                if ({gnt, sel} !== {(n == 72) ? 2'b10 : 2'b01, 6'b011111}) begin
                    miscompares++;
                    $display("FAIL rr_switch n=%0d got %b %b", n, gnt, sel);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_hold_release();
        req = 2'b01; val0 = 24'h654321;
        do_reset();
        repeat (100) begin
            step();
            if (n == 30) req = 2'b00;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL hold n=%0d got %b exp %b", n, obs_v, exp_v);
            end
            vectors++;
            if (n == 71 || n >= 72) begin
                if (gnt !== ((n == 71) ? 2'b01 : 2'b00) || (n >= 72 && sel !== 6'b111111)) begin
                    miscompares++;
                    $display("FAIL hold_dir n=%0d got %b %b", n, gnt, sel);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_no_tearing();
        req = 2'b01; val0 = 24'h111111;
        do_reset();
        repeat (60) begin
            step();
            if (n == 32) val0 = 24'h222222;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL tear n=%0d got %b exp %b", n, obs_v, exp_v);
            end
            vectors++;
            if (n == 47 || n == 48) begin
                if (dig !== ((n == 47) ? 4'h1 : 4'h2)) begin
                    miscompares++;
                    $display("FAIL tear_dir n=%0d got %h", n, dig);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_async_reset();
        req = 2'b01; val0 = 24'h13579B;
        do_reset();
        repeat (36) step();
        rst_n = 1'b0;
        #1;
        if (obs_v !== {2'b00, 6'b111111, 4'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_rst got %b exp all-idle", obs_v);
        end
        vectors++;
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (30) begin
            step();
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL async n=%0d got %b exp %b", n, obs_v, exp_v);
            end
            vectors++;
            if (n == 23 || n == 24) begin
                if (gnt !== ((n == 24) ? 2'b01 : 2'b00)) begin
                    miscompares++;
                    $display("FAIL regrant n=%0d got %b", n, gnt);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_lzb();
        int c;
        req = 2'b01; val0 = 24'h000405; dot0 = 6'h00;
        do_reset();
        repeat (72) begin
            step();
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL lzb n=%0d got %b exp %b", n, obs_v, exp_v);
            end
            vectors++;
            c = (n / SD) % 6;
            if (n >= 24 && c < 3) begin
`ifdef DIG6_LZB_EN
                if (sel !== 6'b111111) begin
`else
                if (sel[c] !== 1'b0) begin
`endif
                    miscompares++;
                    $display("FAIL lzb_dir n=%0d got %b", n, sel);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (900) begin
            if ($urandom_range(7) == 0) req = 2'($urandom);
            if ($urandom_range(3) == 0) begin
                val0 = 24'($urandom);
                val1 = ($urandom_range(1) == 0) ? 24'h0 : 24'($urandom);
                dot0 = 6'($urandom);
                dot1 = ($urandom_range(1) == 0) ? 6'h0 : 6'($urandom);
            end
            step();
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL random n=%0d got %b exp %b", n, obs_v, exp_v);
            end
            vectors++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_owner();
        test_round_robin();
        test_hold_release();
        test_no_tearing();
        test_async_reset();
        test_lzb();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
